// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with valid/ready word interfaces.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    count;
    logic             br;
    logic             borrow_r;
    logic             out_valid_r;

    logic a0, b0, d, br_next;
    logic accept, last, release_done;

    assign a0      = sa[0];
    assign b0      = sb[0];
    assign d       = a0 ^ b0 ^ br;
    // Borrow generate: majority(~a0, b0, br).
    assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);

    assign in_ready     = (state == IDLE) && !rst;
    assign accept       = in_valid && in_ready;
    assign last         = (state == RUN) && (count == LAST);
    assign release_done = (state == DONE) && out_ready;

    assign bit_valid = (state == RUN) && !rst;
    assign bit_out   = bit_valid & d;
    assign busy      = (state != IDLE) && !rst;

    assign diff      = diff_r;
    assign borrow    = borrow_r;
    assign out_valid = out_valid_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sa          <= '0;
            sb          <= '0;
            diff_r      <= '0;
            count       <= '0;
            br          <= 1'b0;
            borrow_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= 1'b0;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    diff_r <= {d, diff_r[WIDTH-1:1]};
                    br     <= br_next;
                    count  <= count + CW'(1);
                    if (last) begin
                        borrow_r    <= br_next;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb, ovf_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                ovf_r <= 1'b0;
            end
            // The last serial bit is the result sign bit.
            if (last) ovf_r <= (a_msb != b_msb) && (d != a_msb);
            if (release_done) ovf_r <= 1'b0;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial WIDTH-bit subtractor computing a − b one bit per clock, LSB first, with a single registered borrow flip-flop. It is the borrow-side counterpart of the carry primitive used in our adder datapath: it generates borrow, not carry. It sits next to the serial adder in the arithmetic library. Operands arrive on a valid/ready word interface; results leave on a second valid/ready interface plus a per-bit serial tap.

## Interface
- WIDTH, default 8, operand and result width in bits, minimum 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand word valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result word valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a − b mod 2^WIDTH.
- borrow  output  1  final borrow out; 1 when a < b unsigned.
- ovf  output  1  signed overflow flag; see Configuration.
- bit_out  output  1  current serial difference bit.
- bit_valid  output  1  bit_out is meaningful this cycle.
- busy  output  1  state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a into shift register sa and b into sb; clear the borrow register br; set count = 0; go to RUN.
- RUN, one bit per cycle, operating on LSBs a0 = sa[0], b0 = sb[0]:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br), i.e. majority(~a0, b0, br).
  - bit_out = d and bit_valid = 1, combinational from current state.
  - Shift sa and sb right by one.
  - Shift d into the MSB of the diff register, so after WIDTH shifts diff[0] holds bit 0.
  - Increment count. When count == WIDTH−1, go to DONE.
- DONE:
  - out_valid = 1; diff, borrow and ovf are stable.
  - Hold until out_ready. On out_valid && out_ready, go to IDLE.
- in_ready = (state == IDLE) && !rst. Operands are never accepted in RUN or DONE.
- in_valid is ignored outside IDLE. a and b are sampled only on the accept edge and may change afterwards.
- Arithmetic rules:
  - count is $clog2(WIDTH)+1 bits wide and must not wrap within an operation.
  - borrow is the br value after the final RUN cycle.
  - diff equals (a − b) mod 2^WIDTH bit-exactly.
- Reset: rst high at any edge, including mid-RUN or mid-DONE, forces IDLE and aborts the operation. No partial result is presented.
- Reset values: in_ready 0 while rst is high, then 1 the cycle after release. out_valid, diff, borrow, ovf, bit_out, bit_valid and busy are all 0.

## Timing
- Accept edge E0 is the edge where in_valid && in_ready is sampled.
- RUN occupies the cycles after edges E0 … E0+WIDTH−1. bit_valid is high for exactly WIDTH cycles. The first bit_out is bit 0, in the cycle after E0.
- out_valid rises after edge E0+WIDTH, so latency is WIDTH cycles from accept to result.
- Without backpressure (out_ready high), the handshake completes at edge E0+WIDTH+1 and in_ready returns after that edge. Minimum initiation interval: WIDTH+2 cycles.
- out_ready low holds DONE indefinitely with all outputs stable.
- Outputs in_ready, bit_out, bit_valid and busy are combinational from registered state and rst. diff, borrow, ovf and out_valid come directly from registers.

## Configuration
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - At the accept edge, latch the operand sign bits a[WIDTH−1] and b[WIDTH−1].
  - At the final RUN cycle, register ovf = (a_msb != b_msb) && (d != a_msb), where d is the last serial bit (the result MSB).
  - ovf is valid in DONE and cleared on reset and on return to IDLE.
- Undefined:
  - ovf is tied to 0.
  - The sign latches and overflow logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x05, b=0x03, out_ready=1 → out_valid 8 cycles after accept; diff=0x02, borrow=0. bit_out sequence 0,1,0,0,0,0,0,0.
- a=0x03, b=0x05 → diff=0xFE, borrow=1, ovf=0.
- a=0x80, b=0x01 → diff=0x7F, borrow=0. ovf=1 with SERIAL_SUB_OVF_EN defined, ovf=0 without it.
- a=0x00, b=0x00, then hold out_ready=0 for 5 cycles → DONE is held, diff=0x00, borrow=0, in_ready=0 throughout. The cycle after out_ready=1, in_ready=1.
- Start a=0xAA, b=0x55 and assert rst during the 4th RUN cycle → next cycle: IDLE, busy=0, bit_valid=0, out_valid=0, never a result. Release rst, then a=0x10, b=0x01 → diff=0x0F, borrow=0.
- Back-to-back in_valid held high with 3 operand pairs → each accepted exactly once, at intervals of WIDTH+2 cycles, with results in order.
